chacha_inv_qr_seq: RTL

- Sequential inverse ChaCha quarter-round: undoes the four add/xor/rotate sub-steps of the forward quarter-round, in reverse order, one sub-step per clock.
- Operates on a latched (a,b,c,d) 32-bit word group with valid/ready handshakes on both sides.
- Used for round-trip self-check of the forward core and for inverse-permutation experiments on the block state.
- Can apply QR_COUNT inverse quarter-rounds back-to-back per transaction.

---
 rtl/chacha_inv_qr_seq_if.sv | 26 ++
 rtl/chacha_inv_qr_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/chacha_inv_qr_seq_if.sv
// Handshake bundle for chacha_inv_qr_seq: input word group in, inverted word group out.
// The master side drives the input group and out_ready; the slave side is the core.
interface chacha_inv_qr_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_in;
    logic [31:0] d_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [31:0] c_out;
    logic [31:0] d_out;

    modport master (
        output in_valid, a_in, b_in, c_in, d_in, out_ready,
        input  in_ready, out_valid, a_out, b_out, c_out, d_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, d_in, out_ready,
        output in_ready, out_valid, a_out, b_out, c_out, d_out
    );
endinterface

// File: rtl/chacha_inv_qr_seq.sv
// Sequential inverse ChaCha quarter-round, QR_COUNT rounds per transaction.
// Define CHACHA_INV_QR_PAIR_EN to retire two chained sub-steps per clock instead of one.
module chacha_inv_qr_seq #(
    parameter int QR_COUNT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chacha_inv_qr_seq_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } quad_t;

    localparam logic [3:0] QR_LAST = 4'(QR_COUNT - 1);

`ifdef CHACHA_INV_QR_PAIR_EN
    localparam logic [1:0] STEP_LAST = 2'd1;
    localparam logic [1:0] STEP_DEC  = 2'd2;
`else
    localparam logic [1:0] STEP_LAST = 2'd0;
    localparam logic [1:0] STEP_DEC  = 2'd1;
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Each step undoes one forward add/xor/rotate pair; the subtraction uses pre-step values.
    function automatic quad_t inv_step(input quad_t q, input logic [1:0] step);
        quad_t r;
        r = q;
        case (step)
            2'd3:    begin r.b = rotr(q.b, 7)  ^ q.c; r.c = q.c - q.d; end
            2'd2:    begin r.d = rotr(q.d, 8)  ^ q.a; r.a = q.a - q.b; end
            2'd1:    begin r.b = rotr(q.b, 12) ^ q.c; r.c = q.c - q.d; end
            default: begin r.d = rotr(q.d, 16) ^ q.a; r.a = q.a - q.b; end
        endcase
        return r;
    endfunction

    state_t     r_state;
    quad_t      r_q;
    quad_t      r_out;
    logic [1:0] r_step;
    logic [3:0] r_qr;
    logic       r_in_ready;
    logic       r_out_valid;
    quad_t      w_next;

`ifdef CHACHA_INV_QR_PAIR_EN
    assign w_next = inv_step(inv_step(r_q, r_step), r_step - 2'd1);
`else
    assign w_next = inv_step(r_q, r_step);
`endif

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_out       <= '0;
            r_step      <= 2'd3;
            r_qr        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_q        <= '{a: bus.a_in, b: bus.b_in, c: bus.c_in, d: bus.d_in};
                        r_step     <= 2'd3;
                        r_qr       <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_q <= w_next;
                    if (r_step == STEP_LAST) begin
                        if (r_qr == QR_LAST) begin
                            r_out       <= w_next;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_qr   <= r_qr + 4'd1;
                            r_step <= 2'd3;
                        end
                    end else begin
                        r_step <= r_step - STEP_DEC;
                    end
                end
                DONE: begin
                    // Input is not considered here, which forces at least one IDLE bubble.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.a_out     = r_out.a;
    assign bus.b_out     = r_out.b;
    assign bus.c_out     = r_out.c;
    assign bus.d_out     = r_out.d;

endmodule
